pcie_tx_cpl_gen: RTL and testbench
==================================

// Module: pcie_tx_cpl_gen
// PURPOSE
//   Builds single-DW Completion-with-Data TLPs (CplD) that answer BAR register reads.
//   Drives the PCIe hard-IP 64-bit Avalon-ST TX port (tx_st_*) directly.
//   Sits between the BAR register-file read path (upstream) and the hard IP (downstream).
//   Honours the hard IP's tx_st_ready latency and accepts one request at a time.
// PARAMETERS
//   READY_LATENCY  2   cycles from tx_st_ready to the cycle in which tx_st_valid may use it (0..3)
//   CNT_W          32  width of the completion counter
// PORTS
//   clk                 in   1      core clock (hard-IP coreclkout domain); sole clock
//   reset               in   1      synchronous, active-high reset
//   completer_id        in   16     {bus,dev,func} captured from config space
//   req_valid           in   1      read-completion request valid
//   req_ready           out  1      request accepted when req_valid && req_ready
//   req_requester_id    in   16     requester ID from the MRd
//   req_tag             in   8      tag from the MRd
//   req_tc              in   3      traffic class from the MRd
//   req_attr            in   2      attr bits {RO,NS} from the MRd
//   req_lower_addr      in   7      MRd address[6:0]; [1:0] are forced to 0 in the header
//   req_data            in   32     register read data
//   tx_st_ready         in   1      hard-IP ready
//   tx_st_valid         out  1      beat valid
//   tx_st_startofpacket out  1      first beat of the TLP
//   tx_st_endofpacket   out  1      last beat of the TLP
//   tx_st_error         out  1      tied 0
//   tx_st_data          out  64     beat data, DW n+1 in [63:32], DW n in [31:0]
//   busy                out  1      a TLP is held or being sent
//   cpl_count           out  CNT_W  number of completed TLPs; wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset: req_ready=1; tx_st_valid/sop/eop/error=0; tx_st_data=0; busy=0; cpl_count=0; FSM=IDLE.
//   Ready qualification: rdy_sr shift register of depth READY_LATENCY.
//     - beat_ok = tx_st_ready delayed by READY_LATENCY cycles (READY_LATENCY=0: beat_ok=tx_st_ready).
//     - tx_st_valid may be 1 only in cycles where beat_ok=1. Never assert valid on an unqualified cycle.
//     - A beat advances the FSM only when valid && beat_ok.
//   Header fields:
//     - DW0 = {1'b0, fmt=2'b10, type=5'b01010, 1'b0, tc, 4'b0, td=0, ep=0, attr, 2'b0, length=10'd1}
//     - DW1 = {completer_id, status=3'b000, bcm=0, byte_count=12'd4}
//     - DW2 = {requester_id, tag, 1'b0, lower_addr[6:2], 2'b00}
//   FSM:
//     - IDLE: req_ready=1. On acceptance, latch all req_* fields into the hold register.
//       Set busy=1, req_ready=0, then go to HDR0.
//     - HDR0: on beat_ok, drive sop=1, data={DW1,DW0}.
//       Next state is HDR2D when lower_addr[2]=1, otherwise HDR2.
//     - HDR2D (address not QW-aligned): on beat_ok, drive data={req_data,DW2}, eop=1, then go to DONE.
//     - HDR2 (address QW-aligned): on beat_ok, drive data={32'h0,DW2}, eop=0, then go to DAT.
//     - DAT: on beat_ok, drive data={32'h0,req_data}, eop=1, then go to DONE.
//     - DONE: single cycle. cpl_count+1, busy=0, req_ready=1, return to IDLE.
//       New requests are accepted the following cycle, so the minimum spacing is one idle cycle per TLP.
//   Latency: request acceptance to first valid beat = 1 cycle, provided beat_ok is 1.
//   Back-pressure and beat boundaries:
//     - A cycle with beat_ok=0 inserts a gap with valid=0.
//     - sop, eop and data change only on accepted beats.
//   Simultaneous events:
//     - req_valid during a non-IDLE state is ignored (req_ready=0).
//     - An eop beat and an incoming req_valid in the same cycle: the request is accepted only after DONE.
//   Reset mid-TLP:
//     - FSM returns to IDLE and the held request is discarded.
//     - Outputs take their reset values the next cycle; the partial TLP is dropped.
//       The hard IP is reset by the same source.
//   cpl_count wraps from all-ones to 0 without saturation.
// STRUCTURE
//   Shared pcie_pkg holds:
//     - TLP fmt/type constants (FMT_3DW_DATA, TYPE_CPL), CPL_STATUS_SC
//     - a typedef for the 3-DW completion header record
//     - a function that packs the header
//   Sub-module pcie_tx_rdy_delay: ready-latency shift register producing beat_ok, parameterised by READY_LATENCY.
//   Everything else stays in this module.
// TESTING
//   1. READY_LATENCY=2, tx_st_ready held 1; req tag=8'h15, rid=16'h0100, la=7'h04, data=32'hDEADBEEF, cid=16'h0300.
//      -> 2 beats: {32'h03000004,32'h4A000001}, then {32'hDEADBEEF,32'h01001504} with eop.
//      -> cpl_count=1.
//   2. Same request with la=7'h08 -> 3 beats: beat1={32'h0,32'h01001508}, beat2={32'h0,32'hDEADBEEF} with eop.
//   3. tx_st_ready toggled 1,0,0,1,... with READY_LATENCY=2.
//      -> tx_st_valid is never 1 when ready 2 cycles earlier was 0.
//      -> beat contents are unchanged across gaps.
//   4. req_valid held high continuously for 4 requests.
//      -> req_ready pulses once per TLP; 4 TLPs emitted; cpl_count=4; busy=0 at the end.
//   5. reset asserted between sop and eop.
//      -> next cycle valid=0, busy=0, req_ready=1, cpl_count=0.
//      -> the next request produces a clean TLP starting with sop.
//   6. cpl_count preloaded to 32'hFFFFFFFF via force, one TLP sent -> cpl_count=0.

Source files
------------

// File: rtl/pcie_pkg.sv
// Shared PCIe TLP definitions: completion header constants, the header record and
// the function that packs it into DW0..DW2.
package pcie_pkg;

  localparam logic [1:0]  FMT_3DW_DATA       = 2'b10;
  localparam logic [4:0]  TYPE_CPL           = 5'b01010;
  localparam logic [2:0]  CPL_STATUS_SC      = 3'b000;
  localparam logic [9:0]  CPL_LENGTH_1DW     = 10'd1;
  localparam logic [11:0] CPL_BYTE_COUNT_1DW = 12'd4;

  typedef struct packed {
    logic [15:0] completer_id;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [6:0]  lower_addr;
  } cpl_hdr_t;

  typedef logic [2:0][31:0] cpl_dws_t;

  function automatic cpl_dws_t pack_cpl_hdr(input cpl_hdr_t h);
    cpl_dws_t dws;
    dws[0] = {1'b0, FMT_3DW_DATA, TYPE_CPL, 1'b0, h.tc, 4'b0000, 1'b0, 1'b0,
              h.attr, 2'b00, CPL_LENGTH_1DW};
    dws[1] = {h.completer_id, CPL_STATUS_SC, 1'b0, CPL_BYTE_COUNT_1DW};
    dws[2] = {h.requester_id, h.tag, 1'b0, h.lower_addr[6:2], 2'b00};
    return dws;
  endfunction

endpackage

// File: rtl/pcie_tx_rdy_delay.sv
// Delays the hard-IP tx_st_ready by READY_LATENCY cycles to give the cycles in
// which a beat may be presented.
module pcie_tx_rdy_delay #(
  parameter int READY_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tx_st_ready,
  output logic beat_ok
);

  generate
    if (READY_LATENCY == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign beat_ok = tx_st_ready;
    end else begin : g_sr
      logic [READY_LATENCY-1:0] rdy_sr;
      always_ff @(posedge clk) begin
        if (reset) begin
          rdy_sr <= '0;
        end else begin
          rdy_sr[0] <= tx_st_ready;
          for (int i = 1; i < READY_LATENCY; i++) begin
            rdy_sr[i] <= rdy_sr[i-1];
          end
        end
      end
      assign beat_ok = rdy_sr[READY_LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/pcie_tx_cpl_gen.sv
// Builds single-DW CplD TLPs for BAR register reads and drives them onto the
// hard-IP 64-bit Avalon-ST TX port, one request at a time.
module pcie_tx_cpl_gen
  import pcie_pkg::*;
#(
  parameter int READY_LATENCY = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      completer_id,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_requester_id,
  input  logic [7:0]       req_tag,
  input  logic [2:0]       req_tc,
  input  logic [1:0]       req_attr,
  input  logic [6:0]       req_lower_addr,
  input  logic [31:0]      req_data,
  input  logic             tx_st_ready,
  output logic             tx_st_valid,
  output logic             tx_st_startofpacket,
  output logic             tx_st_endofpacket,
  output logic             tx_st_error,
  output logic [63:0]      tx_st_data,
  output logic             busy,
  output logic [CNT_W-1:0] cpl_count
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR2D, HDR2, DAT, DONE} state_t;

  state_t      state, state_nxt;
  logic        beat_ok;
  logic        accept;
  cpl_hdr_t    hold_hdr;
  logic [31:0] hold_data;
  cpl_dws_t    dws;

  pcie_tx_rdy_delay #(
    .READY_LATENCY (READY_LATENCY)
  ) u_rdy_delay (
    .clk         (clk),
    .reset       (reset),
    .tx_st_ready (tx_st_ready),
    .beat_ok     (beat_ok)
  );

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready;
  assign busy        = (state != IDLE);
  assign tx_st_error = 1'b0;
  assign dws         = pack_cpl_hdr(hold_hdr);

  // Request capture: held fields stay stable for the whole TLP.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_hdr.completer_id <= completer_id;
      hold_hdr.requester_id <= req_requester_id;
      hold_hdr.tag          <= req_tag;
      hold_hdr.tc           <= req_tc;
      hold_hdr.attr         <= req_attr;
      hold_hdr.lower_addr   <= req_lower_addr;
      hold_data             <= req_data;
    end
  end

  // State and completion counter; the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpl_count <= '0;
    end else begin
      state     <= state_nxt;
      cpl_count <= cpl_count + CNT_W'(state == DONE);
    end
  end

  // Data follows the state, so it only changes once a beat is taken; valid,
  // sop and eop are gated by beat_ok so no beat lands on an unqualified cycle.
  always_comb begin
    state_nxt           = state;
    tx_st_valid         = 1'b0;
    tx_st_startofpacket = 1'b0;
    tx_st_endofpacket   = 1'b0;
    tx_st_data          = '0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = HDR0;
      end
      HDR0: begin
        tx_st_data          = {dws[1], dws[0]};
        tx_st_valid         = beat_ok;
        tx_st_startofpacket = beat_ok;
        if (beat_ok) state_nxt = hold_hdr.lower_addr[2] ? HDR2D : HDR2;
      end
      HDR2D: begin
        tx_st_data        = {hold_data, dws[2]};
        tx_st_valid       = beat_ok;
        tx_st_endofpacket = beat_ok;
        if (beat_ok) state_nxt = DONE;
      end
      HDR2: begin
        tx_st_data  = {32'h0, dws[2]};
        tx_st_valid = beat_ok;
        if (beat_ok) state_nxt = DAT;
      end
      DAT: begin
        tx_st_data        = {32'h0, hold_data};
        tx_st_valid       = beat_ok;
        tx_st_endofpacket = beat_ok;
        if (beat_ok) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pcie_tx_cpl_gen.sv
// Directed bench for pcie_tx_cpl_gen with READY_LATENCY=2: header packing, both
// address alignments, ready back-pressure, back-to-back requests, reset and wrap.
module tb_pcie_tx_cpl_gen;

  localparam int RL = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   completer_id;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_requester_id;
  logic [7:0]    req_tag;
  logic [2:0]    req_tc;
  logic [1:0]    req_attr;
  logic [6:0]    req_lower_addr;
  logic [31:0]   req_data;
  logic          tx_st_ready;
  logic          tx_st_valid;
  logic          tx_st_startofpacket;
  logic          tx_st_endofpacket;
  logic          tx_st_error;
  logic [63:0]   tx_st_data;
  logic          busy;
  logic [CW-1:0] cpl_count;

  pcie_tx_cpl_gen #(.READY_LATENCY(RL), .CNT_W(CW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .completer_id        (completer_id),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_requester_id    (req_requester_id),
    .req_tag             (req_tag),
    .req_tc              (req_tc),
    .req_attr            (req_attr),
    .req_lower_addr      (req_lower_addr),
    .req_data            (req_data),
    .tx_st_ready         (tx_st_ready),
    .tx_st_valid         (tx_st_valid),
    .tx_st_startofpacket (tx_st_startofpacket),
    .tx_st_endofpacket   (tx_st_endofpacket),
    .tx_st_error         (tx_st_error),
    .tx_st_data          (tx_st_data),
    .busy                (busy),
    .cpl_count           (cpl_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_beats, n_sop, n_eop, n_viol, acc_cyc;
  logic [63:0] beat_d [8];
  logic        beat_sop [8];
  logic        beat_eop [8];
  int          beat_cyc [8];
  logic [3:0]  rpat = 4'b1111;
  int          rpi  = 0;
  logic [1:0]  rhist = 2'b11;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, record beats, police ready qualification,
  // then drive tx_st_ready for this cycle from the pattern.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_st_valid && !rhist[1]) n_viol++;
    if (tx_st_valid) begin
      if (tx_st_startofpacket) n_sop++;
      if (tx_st_endofpacket)   n_eop++;
      if (n_beats < 8) begin
        beat_d[n_beats]   = tx_st_data;
        beat_sop[n_beats] = tx_st_startofpacket;
        beat_eop[n_beats] = tx_st_endofpacket;
        beat_cyc[n_beats] = cyc;
      end
      n_beats++;
    end
    tx_st_ready = rpat[rpi % 4];
    rpi++;
    rhist = {rhist[0], tx_st_ready};
  endtask

  task automatic set_req(input logic [15:0] rid, input logic [7:0] tag,
                         input logic [6:0] la, input logic [31:0] d);
    req_requester_id = rid;
    req_tag          = tag;
    req_lower_addr   = la;
    req_data         = d;
  endtask

  task automatic run_req(input logic [15:0] rid, input logic [7:0] tag,
                         input logic [6:0] la, input logic [31:0] d);
    int guard;
    n_beats = 0;
    set_req(rid, tag, la, d);
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin tick(); guard++; end
    acc_cyc = cyc;
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin tick(); guard++; end
  endtask

  initial begin
    int guard, acc, dbl;
    logic prev_rr;
    reset = 1'b1; completer_id = 16'h0300; req_valid = 1'b0;
    req_tc = 3'd0; req_attr = 2'd0; tx_st_ready = 1'b1;
    set_req(16'h0, 8'h0, 7'h0, 32'h0);
    n_beats = 0; n_sop = 0; n_eop = 0; n_viol = 0;
    repeat (3) tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_valid_sop_eop_err",
          64'({tx_st_valid, tx_st_startofpacket, tx_st_endofpacket, tx_st_error}), 64'd0);
    check("rst_data", tx_st_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(cpl_count), 64'd0);
    reset = 1'b0;
    repeat (3) tick();

    // 1: unaligned address, two beats
    run_req(16'h0100, 8'h15, 7'h04, 32'hDEADBEEF);
    check("t1_nbeats", 64'(n_beats), 64'd2);
    check("t1_latency", 64'(beat_cyc[0] - acc_cyc), 64'd1);
    check("t1_beat0", beat_d[0], {32'h03000004, 32'h4A000001});
    check("t1_sop_eop0", 64'({beat_sop[0], beat_eop[0]}), 64'b10);
    check("t1_beat1", beat_d[1], {32'hDEADBEEF, 32'h01001504});
    check("t1_sop_eop1", 64'({beat_sop[1], beat_eop[1]}), 64'b01);
    check("t1_count", 64'(cpl_count), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);

    // 2: QW-aligned address, three beats
    run_req(16'h0100, 8'h15, 7'h08, 32'hDEADBEEF);
    check("t2_nbeats", 64'(n_beats), 64'd3);
    check("t2_beat0", beat_d[0], {32'h03000004, 32'h4A000001});
    check("t2_beat1", beat_d[1], {32'h0, 32'h01001508});
    check("t2_beat2", beat_d[2], {32'h0, 32'hDEADBEEF});
    check("t2_eops", 64'({beat_eop[0], beat_eop[1], beat_eop[2]}), 64'b001);
    check("t2_count", 64'(cpl_count), 64'd2);

    // 3: ready pattern 1,0,0,1 repeating
    rpat = 4'b1001; rpi = 0; n_viol = 0;
    run_req(16'h0100, 8'h15, 7'h08, 32'hDEADBEEF);
    check("t3_unqualified_valid", 64'(n_viol), 64'd0);
    check("t3_nbeats", 64'(n_beats), 64'd3);
    check("t3_beat0", beat_d[0], {32'h03000004, 32'h4A000001});
    check("t3_beat1", beat_d[1], {32'h0, 32'h01001508});
    check("t3_beat2", beat_d[2], {32'h0, 32'hDEADBEEF});
    check("t3_count", 64'(cpl_count), 64'd3);
    rpat = 4'b1111;
    repeat (3) tick();

    // 4: req_valid held high for four requests
    n_sop = 0; n_eop = 0; n_beats = 0; acc = 0; dbl = 0; prev_rr = 1'b0;
    set_req(16'h0200, 8'h21, 7'h04, 32'h12345678);
    req_valid = 1'b1;
    guard = 0;
    while (acc < 4 && guard < 200) begin
      if (req_ready) acc++;
      if (req_ready && prev_rr) dbl++;
      prev_rr = req_ready;
      tick(); guard++;
    end
    req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin tick(); guard++; end
    check("t4_accepts", 64'(acc), 64'd4);
    check("t4_ready_pulse", 64'(dbl), 64'd0);
    check("t4_sops", 64'(n_sop), 64'd4);
    check("t4_eops", 64'(n_eop), 64'd4);
    check("t4_count", 64'(cpl_count), 64'd7);
    check("t4_busy", 64'(busy), 64'd0);

    // 5: reset between sop and eop
    n_beats = 0;
    set_req(16'h0100, 8'h15, 7'h08, 32'hCAFEF00D);
    req_valid = 1'b1;
    guard = 0;
    while (n_beats < 1 && guard < 50) begin tick(); guard++; end
    req_valid = 1'b0;
    check("t5_partial_sop", 64'(beat_sop[0]), 64'd1);
    reset = 1'b1;
    tick();
    check("t5_valid", 64'(tx_st_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd1);
    check("t5_count", 64'(cpl_count), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    run_req(16'h0100, 8'h15, 7'h04, 32'hDEADBEEF);
    check("t5_clean_nbeats", 64'(n_beats), 64'd2);
    check("t5_clean_sop", 64'({beat_sop[0], beat_sop[1]}), 64'b10);
    check("t5_clean_beat0", beat_d[0], {32'h03000004, 32'h4A000001});
    check("t5_clean_count", 64'(cpl_count), 64'd1);

    // 6: counter wrap
    force dut.cpl_count = 32'hFFFFFFFF;
    tick();
    release dut.cpl_count;
    run_req(16'h0100, 8'h15, 7'h04, 32'hDEADBEEF);
    check("t6_wrap", 64'(cpl_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
